// File: rtl/axi4_lite_gpu_if.sv
// AXI4-Lite control-port bundle for the pixel GPU (five channels).
interface axi4_lite_gpu_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_gpu.sv
// AXI4-Lite slave: capability/geometry readback and single-pixel plotting
// into the framebuffer BRAM through a write-only port.
module axi4_lite_gpu #(
    parameter int unsigned FRAME_WIDTH_SCALED  = 640,
    parameter int unsigned FRAME_HEIGHT_SCALED = 480,
    parameter int unsigned AXI_ADDRESS_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH      = 32,
    parameter int unsigned FBUF_ADDR_WIDTH     = 19,
    parameter int unsigned FBUF_DATA_WIDTH     = 8
) (
    input  logic                       s_axi_ctrl_aclk,
    input  logic                       s_axi_ctrl_aresetn,
    axi4_lite_gpu_if.slave             s_axi_ctrl,
    input  logic                       fbuf_rst_busy,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic                       fbuf_rst_req_n
);
    localparam int unsigned WDATA_KEEP = 27;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] SEL_PIXEL   = 2'd0;
    localparam logic [1:0] SEL_GEOM    = 2'd1;

    typedef enum logic [1:0] {R_IDLE, R_LATCH, R_DATA} rd_state_t;
    typedef enum logic [2:0] {W_ADDR, W_DATA, W_EXEC, W_POST, W_RESP} wr_state_t;

    // ---------------- read path ----------------
    rd_state_t               r_rd_state, w_rd_state_nxt;
    logic                    r_arready, w_arready_nxt;
    logic                    r_rvalid, w_rvalid_nxt;
    logic [AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]              r_rresp, w_rresp_nxt;
    logic [1:0]              r_rd_sel, w_rd_sel_nxt;

    // Read state register and registered read-channel outputs
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_sel   <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
        end
    end

    // Read next-state: accept address, decode register, hold data until taken
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = 1'b0;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        w_rd_sel_nxt   = r_rd_sel;
        case (r_rd_state)
            R_IDLE: begin
                if (s_axi_ctrl.arvalid && !r_arready) begin
                    w_rd_sel_nxt   = s_axi_ctrl.araddr[3:2];
                    w_arready_nxt  = 1'b1;
                    w_rd_state_nxt = R_LATCH;
                end
            end
            R_LATCH: begin
                w_rvalid_nxt   = 1'b1;
                w_rd_state_nxt = R_DATA;
                case (r_rd_sel)
                    SEL_PIXEL: begin
                        w_rdata_nxt = AXI_DATA_WIDTH'(32'h0000_0018);
                        w_rresp_nxt = RESP_OKAY;
                    end
                    SEL_GEOM: begin
                        w_rdata_nxt = AXI_DATA_WIDTH'({16'(FRAME_HEIGHT_SCALED),
                                                       16'(FRAME_WIDTH_SCALED)});
                        w_rresp_nxt = RESP_OKAY;
                    end
                    default: begin
                        w_rdata_nxt = '1;
                        w_rresp_nxt = RESP_SLVERR;
                    end
                endcase
            end
            R_DATA: begin
                if (r_rvalid && s_axi_ctrl.rready) begin
                    w_rvalid_nxt   = 1'b0;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    assign s_axi_ctrl.arready = r_arready;
    assign s_axi_ctrl.rvalid  = r_rvalid;
    assign s_axi_ctrl.rdata   = r_rdata;
    assign s_axi_ctrl.rresp   = r_rresp;

    // ---------------- write path ----------------
    wr_state_t                  r_wr_state, w_wr_state_nxt;
    logic                       r_awready, w_awready_nxt;
    logic                       r_wready, w_wready_nxt;
    logic                       r_bvalid, w_bvalid_nxt;
    logic [1:0]                 r_bresp, w_bresp_nxt;
    logic [1:0]                 r_bresp_pend, w_bresp_pend_nxt;
    logic [1:0]                 r_wr_sel, w_wr_sel_nxt;
    logic [WDATA_KEEP-1:0]      r_wdata, w_wdata_nxt;
    logic                       r_en_wr, w_en_wr_nxt;
    logic                       r_wrea, w_wrea_nxt;
    logic [FBUF_ADDR_WIDTH-1:0] r_fbuf_addr, w_fbuf_addr_nxt;
    logic [FBUF_DATA_WIDTH-1:0] r_fbuf_data, w_fbuf_data_nxt;
    logic                       r_rst_req_n, w_rst_req_n_nxt;

    // Pixel field decode and linear address at full precision
    logic [9:0]  w_pix_x;
    logic [8:0]  w_pix_y;
    logic [31:0] w_pix_lin;
    logic        w_pix_in_range;
    assign w_pix_x        = r_wdata[17:8];
    assign w_pix_y        = r_wdata[26:18];
    assign w_pix_lin      = 32'(w_pix_y) * 32'(FRAME_WIDTH_SCALED) + 32'(w_pix_x);
    assign w_pix_in_range = (32'(w_pix_x) < 32'(FRAME_WIDTH_SCALED)) &&
                            (32'(w_pix_y) < 32'(FRAME_HEIGHT_SCALED));

    // Write state register and registered write/BRAM outputs
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            r_wr_state   <= W_ADDR;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_bresp_pend <= RESP_OKAY;
            r_wr_sel     <= '0;
            r_wdata      <= '0;
            r_en_wr      <= 1'b0;
            r_wrea       <= 1'b0;
            r_fbuf_addr  <= '0;
            r_fbuf_data  <= '0;
            r_rst_req_n  <= 1'b1;
        end else begin
            r_wr_state   <= w_wr_state_nxt;
            r_awready    <= w_awready_nxt;
            r_wready     <= w_wready_nxt;
            r_bvalid     <= w_bvalid_nxt;
            r_bresp      <= w_bresp_nxt;
            r_bresp_pend <= w_bresp_pend_nxt;
            r_wr_sel     <= w_wr_sel_nxt;
            r_wdata      <= w_wdata_nxt;
            r_en_wr      <= w_en_wr_nxt;
            r_wrea       <= w_wrea_nxt;
            r_fbuf_addr  <= w_fbuf_addr_nxt;
            r_fbuf_data  <= w_fbuf_data_nxt;
            r_rst_req_n  <= w_rst_req_n_nxt;
        end
    end

    // Write next-state: address, data, execute (pixel / BRAM reset), respond
    always_comb begin
        w_wr_state_nxt   = r_wr_state;
        w_awready_nxt    = 1'b0;
        w_wready_nxt     = 1'b0;
        w_bvalid_nxt     = r_bvalid;
        w_bresp_nxt      = r_bresp;
        w_bresp_pend_nxt = r_bresp_pend;
        w_wr_sel_nxt     = r_wr_sel;
        w_wdata_nxt      = r_wdata;
        w_en_wr_nxt      = 1'b0;
        w_wrea_nxt       = 1'b0;
        w_fbuf_addr_nxt  = r_fbuf_addr;
        w_fbuf_data_nxt  = r_fbuf_data;
        w_rst_req_n_nxt  = 1'b1;
        case (r_wr_state)
            W_ADDR: begin
                if (s_axi_ctrl.awvalid && !r_awready) begin
                    w_wr_sel_nxt   = s_axi_ctrl.awaddr[3:2];
                    w_awready_nxt  = 1'b1;
                    w_wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_ctrl.wvalid && !r_wready) begin
                    w_wdata_nxt    = s_axi_ctrl.wdata[WDATA_KEEP-1:0];
                    w_wready_nxt   = 1'b1;
                    w_wr_state_nxt = W_EXEC;
                end
            end
            W_EXEC: begin
                case (r_wr_sel)
                    SEL_PIXEL: begin
                        if (!w_pix_in_range) begin
                            w_bresp_pend_nxt = RESP_SLVERR;
                            w_wr_state_nxt   = W_POST;
                        end else if (!fbuf_rst_busy) begin
                            w_en_wr_nxt      = 1'b1;
                            w_wrea_nxt       = 1'b1;
                            w_fbuf_addr_nxt  = FBUF_ADDR_WIDTH'(w_pix_lin);
                            w_fbuf_data_nxt  = FBUF_DATA_WIDTH'(r_wdata[7:0]);
                            w_bresp_pend_nxt = RESP_OKAY;
                            w_wr_state_nxt   = W_POST;
                        end
                    end
                    SEL_GEOM: begin
                        w_rst_req_n_nxt  = ~r_wdata[0];
                        w_bresp_pend_nxt = RESP_OKAY;
                        w_wr_state_nxt   = W_POST;
                    end
                    default: begin
                        w_bresp_pend_nxt = RESP_SLVERR;
                        w_wr_state_nxt   = W_POST;
                    end
                endcase
            end
            W_POST: begin
                w_bvalid_nxt   = 1'b1;
                w_bresp_nxt    = r_bresp_pend;
                w_wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                if (r_bvalid && s_axi_ctrl.bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_wr_state_nxt = W_ADDR;
                end
            end
            default: w_wr_state_nxt = W_ADDR;
        endcase
    end

    assign s_axi_ctrl.awready = r_awready;
    assign s_axi_ctrl.wready  = r_wready;
    assign s_axi_ctrl.bvalid  = r_bvalid;
    assign s_axi_ctrl.bresp   = r_bresp;
    assign fbuf_en_wr         = r_en_wr;
    assign fbuf_wrea          = r_wrea;
    assign fbuf_addr          = r_fbuf_addr;
    assign fbuf_data          = r_fbuf_data;
    assign fbuf_rst_req_n     = r_rst_req_n;

    // Address/data bits outside the decoded fields are intentionally ignored
    logic w_unused;
    assign w_unused = &{1'b0,
                        s_axi_ctrl.araddr[AXI_ADDRESS_WIDTH-1:4], s_axi_ctrl.araddr[1:0],
                        s_axi_ctrl.awaddr[AXI_ADDRESS_WIDTH-1:4], s_axi_ctrl.awaddr[1:0],
                        s_axi_ctrl.wdata[AXI_DATA_WIDTH-1:WDATA_KEEP],
                        w_pix_lin[31:FBUF_ADDR_WIDTH]};
endmodule

// File: tb/tb_axi4_lite_gpu.sv
// Scoreboard bench for axi4_lite_gpu: drivers push expectations from a
// register-map model, negedge monitors pop and compare DUT responses.
module tb_axi4_lite_gpu;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned FAW = 19;
    localparam int unsigned FDW = 8;
    localparam int unsigned FW  = 640;
    localparam int unsigned FH  = 480;
    localparam int          TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_lite_gpu_if #(.AW(AW), .DW(DW)) bus ();

    logic           fbuf_rst_busy;
    logic           fbuf_en_wr;
    logic           fbuf_wrea;
    logic [FAW-1:0] fbuf_addr;
    logic [FDW-1:0] fbuf_data;
    logic           fbuf_rst_req_n;

    axi4_lite_gpu #(
        .FRAME_WIDTH_SCALED (FW),
        .FRAME_HEIGHT_SCALED(FH),
        .AXI_ADDRESS_WIDTH  (AW),
        .AXI_DATA_WIDTH     (DW),
        .FBUF_ADDR_WIDTH    (FAW),
        .FBUF_DATA_WIDTH    (FDW)
    ) dut (
        .s_axi_ctrl_aclk   (clk),
        .s_axi_ctrl_aresetn(rst_n),
        .s_axi_ctrl        (bus),
        .fbuf_rst_busy     (fbuf_rst_busy),
        .fbuf_en_wr        (fbuf_en_wr),
        .fbuf_wrea         (fbuf_wrea),
        .fbuf_addr         (fbuf_addr),
        .fbuf_data         (fbuf_data),
        .fbuf_rst_req_n    (fbuf_rst_req_n)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rd_done = 0, n_wr_done = 0, n_pix_seen = 0;
    int n_rst_exp = 0, n_rst_seen = 0;
    longint cyc = 0;

    logic [DW+1:0]      q_rd[$];
    logic [1:0]         q_b[$];
    logic [FAW+FDW-1:0] q_pix[$];

    logic rand_ready = 1'b0, ready_fixed = 1'b1;
    logic rand_busy  = 1'b0, busy_fixed  = 1'b0;
    logic busy_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ready / busy stimulus, changed just after each rising edge
    initial begin
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        fbuf_rst_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
            bus.bready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
            fbuf_rst_busy = rand_busy ? ($urandom_range(0, 5) == 0) : busy_fixed;
        end
    end

    // Reference model: what the register map says a read returns
    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] a);
        case (a[3:2])
            2'd0:    return {32'h0000_0018, 2'b00};
            2'd1:    return {16'(FH), 16'(FW), 2'b00};
            default: return {32'hFFFF_FFFF, 2'b10};
        endcase
    endfunction

    // Reference model: expected BRAM write, reset pulse and response of a write
    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned x, y;
        x = 32'(d[17:8]);
        y = 32'(d[26:18]);
        case (a[3:2])
            2'd0: begin
                if (x < FW && y < FH) begin
                    q_pix.push_back({FAW'(y * FW + x), d[7:0]});
                    q_b.push_back(2'b00);
                end else begin
                    q_b.push_back(2'b10);
                end
            end
            2'd1: begin
                if (d[0]) n_rst_exp++;
                q_b.push_back(2'b00);
            end
            default: q_b.push_back(2'b10);
        endcase
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.arready;
            1:       return bus.awready;
            2:       return bus.wready;
            3:       return bus.rvalid;
            default: return bus.bvalid;
        endcase
    endfunction

    task automatic wait_hi(input string name, input int which, output longint t);
        t = 0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk);
            #1;
            if (sig(which)) begin
                t = cyc;
                return;
            end
        end
        flag({name, " timeout"});
    endtask

    task automatic wait_done(input string name, input int is_wr, input int target);
        for (int i = 0; i < TMO; i++) begin
            if ((is_wr != 0 ? n_wr_done : n_rd_done) >= target) return;
            @(posedge clk);
            #1;
        end
        flag({name, " completion timeout"});
    endtask

    task automatic do_read(input logic [AW-1:0] a, output longint t_iss, output longint t_ar,
                           output longint t_rv);
        int target;
        target = n_rd_done + 1;
        q_rd.push_back(model_read(a));
        @(posedge clk);
        #1;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        t_iss = cyc;
        wait_hi("arready", 0, t_ar);
        bus.arvalid = 1'b0;
        wait_hi("rvalid", 3, t_rv);
        wait_done("read", 0, target);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output longint t_w, output longint t_b);
        int target;
        longint t_aw;
        target = n_wr_done + 1;
        model_write(a, d);
        @(posedge clk);
        #1;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wvalid  = 1'b1;
        wait_hi("awready", 1, t_aw);
        bus.awvalid = 1'b0;
        wait_hi("wready", 2, t_w);
        bus.wvalid = 1'b0;
        wait_hi("bvalid", 4, t_b);
        wait_done("write", 1, target);
    endtask

    // Monitors: compare every handshake / BRAM write against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rvalid && bus.rready) begin
                if (q_rd.size() == 0) flag("unexpected read response");
                else check("read data/resp", {bus.rdata, bus.rresp}, q_rd.pop_front());
                n_rd_done++;
            end
            if (bus.bvalid && bus.bready) begin
                if (q_b.size() == 0) flag("unexpected write response");
                else check("bresp", 64'(bus.bresp), 64'(q_b.pop_front()));
                n_wr_done++;
            end
            if (fbuf_wrea || fbuf_en_wr) begin
                check("bram en_wr==wrea", {fbuf_en_wr, fbuf_wrea}, 2'b11);
                check("bram write while busy", 64'(busy_prev), 64'(0));
                if (q_pix.size() == 0) flag("unexpected bram write");
                else check("bram addr/data", {fbuf_addr, fbuf_data}, q_pix.pop_front());
                n_pix_seen++;
            end
            if (!fbuf_rst_req_n) n_rst_seen++;
        end
        busy_prev = fbuf_rst_busy;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1, t2;
        int npix;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.arvalid = 1'b0; bus.araddr = '0;
        bus.awvalid = 1'b0; bus.awaddr = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0;

        // reset held 100 ns: no ready/valid may rise
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset handshakes", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 5'b0);
        end
        check("reset data outputs", {bus.rdata, bus.rresp, bus.bresp, fbuf_addr, fbuf_data},
              64'(0));
        check("reset bram ctl", {fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n}, 3'b001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // directed reads: latency and register map
        do_read(32'h0, t0, t1, t2);
        check("arready latency", 64'(t1 - t0), 64'(1));
        check("rvalid after arready", 64'(t2 - t1), 64'(1));
        do_read(32'h4, t0, t1, t2);
        check("rvalid dropped after rready", 64'(bus.rvalid), 64'(0));
        do_read(32'h8, t0, t1, t2);

        // directed writes
        do_write(32'h0, 32'h0078_0FE3, t0, t1);
        check("wready->bvalid latency", 64'(t1 - t0), 64'(2));
        do_write(32'h4, 32'h1, t0, t1);
        do_write(32'hC, 32'h1234_5678, t0, t1);
        do_write(32'h0, {5'd0, 9'd10, 10'd640, 8'h55}, t0, t1);
        do_write(32'h0, {5'd0, 9'd480, 10'd0, 8'h66}, t0, t1);
        do_write(32'h0, {5'd0, 9'd479, 10'd639, 8'h77}, t0, t1);

        // pixel write stalls while the BRAM is still in reset
        busy_fixed = 1'b1;
        repeat (2) @(posedge clk);
        npix = n_pix_seen;
        fork
            do_write(32'h0, {5'd0, 9'd3, 10'd7, 8'hA5}, t0, t1);
            begin
                repeat (12) @(posedge clk);
                #2;
                check("no bram write while busy", 64'(n_pix_seen), 64'(npix));
                check("no bvalid while busy", 64'(bus.bvalid), 64'(0));
                busy_fixed = 1'b0;
            end
        join
        check("one write after busy drops", 64'(n_pix_seen), 64'(npix + 1));

        // randomized concurrent traffic
        rand_ready = 1'b1;
        rand_busy  = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                a = ($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3) << 2);
                do_read(a, t0, t1, t2);
            end
            for (int i = 0; i < 40; i++) begin
                a = ($urandom() & 32'hFFFF_FFF0) |
                    32'(($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3)) << 2;
                d = {5'($urandom()), 9'($urandom_range(0, 520)), 10'($urandom_range(0, 700)),
                     8'($urandom())};
                do_write(a, d, t0, t1);
            end
        join
        rand_ready = 1'b0;
        rand_busy  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("read queue drained", 64'(q_rd.size()), 64'(0));
        check("bresp queue drained", 64'(q_b.size()), 64'(0));
        check("pixel queue drained", 64'(q_pix.size()), 64'(0));
        check("bram reset pulses", 64'(n_rst_seen), 64'(n_rst_exp));

        // reset in the middle of a read and a stalled pixel write
        ready_fixed = 1'b0;
        busy_fixed  = 1'b1;
        @(posedge clk);
        #1;
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        bus.awaddr = 32'h0; bus.awvalid = 1'b1;
        bus.wdata  = {5'd0, 9'd1, 10'd1, 8'h11}; bus.wvalid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("read pending before abort", 64'(bus.rvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort handshakes", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}, 5'b0);
        check("abort data outputs", {bus.rdata, bus.rresp, bus.bresp, fbuf_addr, fbuf_data},
              64'(0));
        check("abort bram ctl", {fbuf_en_wr, fbuf_wrea, fbuf_rst_req_n}, 3'b001);
        @(negedge clk);
        check("abort arready held low", 64'(bus.arready), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
